// File: rtl/nbit_mul_div_unit_pkg.sv
// Shared definitions for the iterative multiply/divide engines:
// FSM state encoding and a two's complement negate/abs helper.
package nbit_mul_div_unit_pkg;

  // Both engines step through the same four phases.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PREP = 2'd1,
    CALC = 2'd2,
    DONE = 2'd3
  } engine_state_t;

  // Working width of the helper; callers cast operands up to this width
  // and truncate the result back to their own width (SIZE or 2*SIZE).
  // Negation modulo 2^HELPER_W truncated to N bits equals negation modulo 2^N.
  localparam int HELPER_W = 256;

  // Conditionally negate a value (two's complement). Absolute value is
  // obtained by passing en = is_signed & sign_bit.
  function automatic logic [HELPER_W-1:0] twos_cond_neg(input logic [HELPER_W-1:0] v,
                                                        input logic                en);
    return en ? (~v + HELPER_W'(1)) : v;
  endfunction

endpackage

// File: rtl/nbit_mul_div_unit_if.sv
// Handshake and data bundle for the divider and multiplier engines.
interface nbit_mul_div_unit_if #(
  parameter int SIZE = 33
);
  // divider channel
  logic              div_start;
  logic              div_is_signed;
  logic [SIZE-1:0]   div_dividend;
  logic [SIZE-1:0]   div_divisor;
  logic              div_ready;
  logic              div_valid;
  logic              div_error;
  logic [SIZE-1:0]   div_quotient;
  logic [SIZE-1:0]   div_remainder;
  // multiplier channel
  logic              mul_start;
  logic              mul_is_signed;
  logic [SIZE-1:0]   mul_multiplicand;
  logic [SIZE-1:0]   mul_multiplier;
  logic              mul_ready;
  logic              mul_valid;
  logic [2*SIZE-1:0] mul_product;

  // Requester side: issues operations, observes results.
  modport master (
    output div_start, div_is_signed, div_dividend, div_divisor,
    input  div_ready, div_valid, div_error, div_quotient, div_remainder,
    output mul_start, mul_is_signed, mul_multiplicand, mul_multiplier,
    input  mul_ready, mul_valid, mul_product
  );

  // Unit side: accepts operations, produces results.
  modport slave (
    input  div_start, div_is_signed, div_dividend, div_divisor,
    output div_ready, div_valid, div_error, div_quotient, div_remainder,
    input  mul_start, mul_is_signed, mul_multiplicand, mul_multiplier,
    output mul_ready, mul_valid, mul_product
  );
endinterface

// File: rtl/nbit_mul_div_unit_div_nbit.sv
// Restoring shift-subtract divider, one quotient bit per cycle,
// fixed latency regardless of operand values (including divide-by-zero).
module div_nbit
  import nbit_mul_div_unit_pkg::*;
#(
  parameter int SIZE = 33
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            is_signed,
  input  logic [SIZE-1:0] dividend,
  input  logic [SIZE-1:0] divisor,
  output logic            ready,
  output logic            valid,
  output logic            error,
  output logic [SIZE-1:0] quotient,
  output logic [SIZE-1:0] remainder
);

  localparam int              CW   = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam logic [CW-1:0]   LAST = CW'(SIZE - 1);

  function automatic logic [SIZE-1:0] cond_neg(input logic [SIZE-1:0] v, input logic en);
    return SIZE'(twos_cond_neg(HELPER_W'(v), en));
  endfunction

  engine_state_t   state_reg, state_next;
  logic            signed_reg, signed_next;
  logic [SIZE-1:0] dividend_reg, dividend_next;   // original dividend, kept for div-by-zero
  logic [SIZE-1:0] divisor_reg, divisor_next;     // raw, then magnitude after PREP
  logic [SIZE-1:0] quo_reg, quo_next;             // dividend magnitude shifting into quotient
  logic [SIZE-1:0] rem_reg, rem_next;             // partial remainder
  logic [CW-1:0]   count_reg, count_next;
  logic            quo_neg_reg, quo_neg_next;
  logic            rem_neg_reg, rem_neg_next;
  logic [SIZE-1:0] quotient_reg, quotient_next;
  logic [SIZE-1:0] remainder_reg, remainder_next;
  logic            error_reg, error_next;

  logic [SIZE:0]   trial;
  logic [SIZE-1:0] quo_step;
  logic [SIZE-1:0] rem_step;

  // One restoring iteration: shift in the next dividend bit and try to subtract.
  // When the trial goes negative the shifted value is below the divisor, so its
  // top bit is zero and it fits back into SIZE bits.
  always_comb begin
    trial = {rem_reg, quo_reg[SIZE-1]} - {1'b0, divisor_reg};
    if (trial[SIZE]) begin
      rem_step = {rem_reg[SIZE-2:0], quo_reg[SIZE-1]};
      quo_step = {quo_reg[SIZE-2:0], 1'b0};
    end else begin
      rem_step = trial[SIZE-1:0];
      quo_step = {quo_reg[SIZE-2:0], 1'b1};
    end
  end

  // Next-state and datapath update for the IDLE/PREP/CALC/DONE sequence.
  always_comb begin
    state_next     = state_reg;
    signed_next    = signed_reg;
    dividend_next  = dividend_reg;
    divisor_next   = divisor_reg;
    quo_next       = quo_reg;
    rem_next       = rem_reg;
    count_next     = count_reg;
    quo_neg_next   = quo_neg_reg;
    rem_neg_next   = rem_neg_reg;
    quotient_next  = quotient_reg;
    remainder_next = remainder_reg;
    error_next     = error_reg;
    case (state_reg)
      IDLE, DONE: begin
        state_next = IDLE;
        if (start) begin
          state_next    = PREP;
          signed_next   = is_signed;
          dividend_next = dividend;
          divisor_next  = divisor;
        end
      end
      PREP: begin
        quo_neg_next = signed_reg & (dividend_reg[SIZE-1] ^ divisor_reg[SIZE-1]);
        rem_neg_next = signed_reg & dividend_reg[SIZE-1];
        quo_next     = cond_neg(dividend_reg, signed_reg & dividend_reg[SIZE-1]);
        divisor_next = cond_neg(divisor_reg, signed_reg & divisor_reg[SIZE-1]);
        rem_next     = '0;
        count_next   = '0;
        state_next   = CALC;
      end
      CALC: begin
        quo_next   = quo_step;
        rem_next   = rem_step;
        count_next = count_reg + CW'(1);
        if (count_reg == LAST) begin
          state_next = DONE;
          if (divisor_reg == '0) begin
            error_next     = 1'b1;
            quotient_next  = '1;
            remainder_next = dividend_reg;
          end else begin
            error_next     = 1'b0;
            quotient_next  = cond_neg(quo_step, quo_neg_reg);
            remainder_next = cond_neg(rem_step, rem_neg_reg);
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Datapath and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      signed_reg    <= 1'b0;
      dividend_reg  <= '0;
      divisor_reg   <= '0;
      quo_reg       <= '0;
      rem_reg       <= '0;
      count_reg     <= '0;
      quo_neg_reg   <= 1'b0;
      rem_neg_reg   <= 1'b0;
      quotient_reg  <= '0;
      remainder_reg <= '0;
      error_reg     <= 1'b0;
    end else begin
      signed_reg    <= signed_next;
      dividend_reg  <= dividend_next;
      divisor_reg   <= divisor_next;
      quo_reg       <= quo_next;
      rem_reg       <= rem_next;
      count_reg     <= count_next;
      quo_neg_reg   <= quo_neg_next;
      rem_neg_reg   <= rem_neg_next;
      quotient_reg  <= quotient_next;
      remainder_reg <= remainder_next;
      error_reg     <= error_next;
    end
  end

  assign ready     = (state_reg == IDLE) || (state_reg == DONE);
  assign valid     = (state_reg == DONE);
  assign error     = error_reg;
  assign quotient  = quotient_reg;
  assign remainder = remainder_reg;

endmodule

// File: rtl/nbit_mul_div_unit_mult_nbit.sv
// Shift-add multiplier over the multiplier bits, one bit per cycle,
// magnitudes multiplied and the sign applied at the end.
module mult_nbit
  import nbit_mul_div_unit_pkg::*;
#(
  parameter int SIZE = 33
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              is_signed,
  input  logic [SIZE-1:0]   multiplicand,
  input  logic [SIZE-1:0]   multiplier,
  output logic              ready,
  output logic              valid,
  output logic [2*SIZE-1:0] product
);

  localparam int            CW   = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam logic [CW-1:0] LAST = CW'(SIZE - 1);

  function automatic logic [SIZE-1:0] cond_neg(input logic [SIZE-1:0] v, input logic en);
    return SIZE'(twos_cond_neg(HELPER_W'(v), en));
  endfunction

  function automatic logic [2*SIZE-1:0] cond_neg2(input logic [2*SIZE-1:0] v, input logic en);
    return (2*SIZE)'(twos_cond_neg(HELPER_W'(v), en));
  endfunction

  engine_state_t     state_reg, state_next;
  logic              signed_reg, signed_next;
  logic [SIZE-1:0]   mcand_reg, mcand_next;     // raw, then magnitude after PREP
  logic [SIZE-1:0]   mplier_reg, mplier_next;   // raw multiplier
  logic [2*SIZE-1:0] prod_reg, prod_next;       // {partial sum, remaining multiplier bits}
  logic              neg_reg, neg_next;
  logic [CW-1:0]     count_reg, count_next;
  logic [2*SIZE-1:0] product_reg, product_next;

  logic [SIZE:0]     sum;
  logic [2*SIZE-1:0] prod_step;

  // One shift-add step: add the multiplicand into the upper half when the
  // current multiplier LSB is set, then shift the whole accumulator right.
  always_comb begin
    sum       = {1'b0, prod_reg[2*SIZE-1:SIZE]} + (prod_reg[0] ? {1'b0, mcand_reg} : '0);
    prod_step = {sum, prod_reg[SIZE-1:1]};
  end

  // Next-state and datapath update for the IDLE/PREP/CALC/DONE sequence.
  always_comb begin
    state_next   = state_reg;
    signed_next  = signed_reg;
    mcand_next   = mcand_reg;
    mplier_next  = mplier_reg;
    prod_next    = prod_reg;
    neg_next     = neg_reg;
    count_next   = count_reg;
    product_next = product_reg;
    case (state_reg)
      IDLE, DONE: begin
        state_next = IDLE;
        if (start) begin
          state_next  = PREP;
          signed_next = is_signed;
          mcand_next  = multiplicand;
          mplier_next = multiplier;
        end
      end
      PREP: begin
        neg_next   = signed_reg & (mcand_reg[SIZE-1] ^ mplier_reg[SIZE-1]);
        mcand_next = cond_neg(mcand_reg, signed_reg & mcand_reg[SIZE-1]);
        prod_next  = {{SIZE{1'b0}}, cond_neg(mplier_reg, signed_reg & mplier_reg[SIZE-1])};
        count_next = '0;
        state_next = CALC;
      end
      CALC: begin
        prod_next  = prod_step;
        count_next = count_reg + CW'(1);
        if (count_reg == LAST) begin
          state_next   = DONE;
          product_next = cond_neg2(prod_step, neg_reg);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Datapath and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      signed_reg  <= 1'b0;
      mcand_reg   <= '0;
      mplier_reg  <= '0;
      prod_reg    <= '0;
      neg_reg     <= 1'b0;
      count_reg   <= '0;
      product_reg <= '0;
    end else begin
      signed_reg  <= signed_next;
      mcand_reg   <= mcand_next;
      mplier_reg  <= mplier_next;
      prod_reg    <= prod_next;
      neg_reg     <= neg_next;
      count_reg   <= count_next;
      product_reg <= product_next;
    end
  end

  assign ready   = (state_reg == IDLE) || (state_reg == DONE);
  assign valid   = (state_reg == DONE);
  assign product = product_reg;

endmodule

// File: rtl/nbit_mul_div_unit.sv
// RV32M-style multiply/divide unit: independent iterative divider and
// multiplier engines sharing one interface bundle.
module nbit_mul_div_unit
  import nbit_mul_div_unit_pkg::*;
#(
  parameter int SIZE = 33
) (
  input logic                 clk,
  input logic                 rst,
  nbit_mul_div_unit_if.slave  bus
);

  div_nbit #(.SIZE(SIZE)) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (bus.div_start),
    .is_signed (bus.div_is_signed),
    .dividend  (bus.div_dividend),
    .divisor   (bus.div_divisor),
    .ready     (bus.div_ready),
    .valid     (bus.div_valid),
    .error     (bus.div_error),
    .quotient  (bus.div_quotient),
    .remainder (bus.div_remainder)
  );

  mult_nbit #(.SIZE(SIZE)) u_mul (
    .clk          (clk),
    .rst          (rst),
    .start        (bus.mul_start),
    .is_signed    (bus.mul_is_signed),
    .multiplicand (bus.mul_multiplicand),
    .multiplier   (bus.mul_multiplier),
    .ready        (bus.mul_ready),
    .valid        (bus.mul_valid),
    .product      (bus.mul_product)
  );

endmodule

// File: tb/tb_nbit_mul_div_unit.sv
// Scoreboard bench for nbit_mul_div_unit: the driver queues hand-computed
// expectations, a monitor pops and compares on every valid pulse.
module tb_nbit_mul_div_unit;

  localparam int SIZE = 33;
  localparam int W2   = 2 * SIZE;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  nbit_mul_div_unit_if #(.SIZE(SIZE)) bus ();

  nbit_mul_div_unit #(.SIZE(SIZE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [SIZE-1:0] q;
    logic [SIZE-1:0] r;
    logic            e;
    int              cyc;
  } div_exp_t;

  typedef struct {
    logic [W2-1:0] p;
    int            cyc;
  } mul_exp_t;

  div_exp_t div_q[$];
  mul_exp_t mul_q[$];

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [W2-1:0] act, input logic [W2-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every valid pulse must match the oldest queued expectation,
  // arrive at the fixed latency, and show ready high.
  always @(negedge clk) begin
    if (bus.div_valid) begin
      if (div_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL div_unexpected_valid: got valid=1 at cycle %0d, expected none", cyc);
      end else begin
        div_exp_t e;
        e = div_q.pop_front();
        $display("[TB] div result q=0x%0h r=0x%0h err=%0b cycle=%0d",
                 bus.div_quotient, bus.div_remainder, bus.div_error, cyc);
        check("div_latency", W2'(cyc), W2'(e.cyc));
        check("div_quotient", W2'(bus.div_quotient), W2'(e.q));
        check("div_remainder", W2'(bus.div_remainder), W2'(e.r));
        check("div_error", W2'(bus.div_error), W2'(e.e));
        check("div_ready_at_valid", W2'(bus.div_ready), W2'(1));
      end
    end
    if (bus.mul_valid) begin
      if (mul_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL mul_unexpected_valid: got valid=1 at cycle %0d, expected none", cyc);
      end else begin
        mul_exp_t m;
        m = mul_q.pop_front();
        $display("[TB] mul result p=0x%0h cycle=%0d", bus.mul_product, cyc);
        check("mul_latency", W2'(cyc), W2'(m.cyc));
        check("mul_product", bus.mul_product, m.p);
        check("mul_ready_at_valid", W2'(bus.mul_ready), W2'(1));
      end
    end
  end

  // Drive a divide request at the current negedge and queue its expectation.
  task automatic div_go(input logic sg, input logic [SIZE-1:0] a, input logic [SIZE-1:0] b,
                        input logic [SIZE-1:0] q, input logic [SIZE-1:0] r, input logic e);
    div_exp_t x;
    bus.div_is_signed = sg;
    bus.div_dividend  = a;
    bus.div_divisor   = b;
    bus.div_start     = 1'b1;
    x.q = q; x.r = r; x.e = e; x.cyc = cyc + SIZE + 2;
    div_q.push_back(x);
    $display("[TB] div issue signed=%0b a=0x%0h b=0x%0h", sg, a, b);
  endtask

  // Drive a multiply request at the current negedge and queue its expectation.
  task automatic mul_go(input logic sg, input logic [SIZE-1:0] a, input logic [SIZE-1:0] b,
                        input logic [W2-1:0] p);
    mul_exp_t x;
    bus.mul_is_signed    = sg;
    bus.mul_multiplicand = a;
    bus.mul_multiplier   = b;
    bus.mul_start        = 1'b1;
    x.p = p; x.cyc = cyc + SIZE + 2;
    mul_q.push_back(x);
    $display("[TB] mul issue signed=%0b a=0x%0h b=0x%0h", sg, a, b);
  endtask

  task automatic release_starts();
    @(negedge clk);
    bus.div_start = 1'b0;
    bus.mul_start = 1'b0;
  endtask

  // Wait (bounded) for all queued results, then a few idle cycles.
  task automatic wait_idle();
    int n;
    n = 0;
    while ((div_q.size() != 0 || mul_q.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      tests++;
      fails++;
      $display("FAIL timeout: %0d div and %0d mul results pending, expected 0",
               div_q.size(), mul_q.size());
      div_q.delete();
      mul_q.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic check_idle_reset(input string tag);
    check({tag, "_div_ready"}, W2'(bus.div_ready), W2'(1));
    check({tag, "_div_valid"}, W2'(bus.div_valid), W2'(0));
    check({tag, "_div_error"}, W2'(bus.div_error), W2'(0));
    check({tag, "_div_quotient"}, W2'(bus.div_quotient), W2'(0));
    check({tag, "_div_remainder"}, W2'(bus.div_remainder), W2'(0));
    check({tag, "_mul_ready"}, W2'(bus.mul_ready), W2'(1));
    check({tag, "_mul_valid"}, W2'(bus.mul_valid), W2'(0));
    check({tag, "_mul_product"}, bus.mul_product, W2'(0));
  endtask

  initial begin
    bus.div_start = 1'b0; bus.div_is_signed = 1'b0; bus.div_dividend = '0; bus.div_divisor = '0;
    bus.mul_start = 1'b0; bus.mul_is_signed = 1'b0; bus.mul_multiplicand = '0; bus.mul_multiplier = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_idle_reset("reset");
    rst = 1'b0;
    @(negedge clk);

    // Unsigned 100/7, then a start mid-operation that must be ignored.
    div_go(1'b0, 33'd100, 33'd7, 33'd14, 33'd2, 1'b0);
    release_starts();
    repeat (4) @(negedge clk);
    check("div_busy_ready", W2'(bus.div_ready), W2'(0));
    bus.div_dividend = 33'd50; bus.div_divisor = 33'd5; bus.div_start = 1'b1;
    release_starts();
    wait_idle();

    // Signed -7 / 2.
    div_go(1'b1, 33'h1_FFFF_FFF9, 33'd2, 33'h1_FFFF_FFFD, 33'h1_FFFF_FFFF, 1'b0);
    release_starts(); wait_idle();

    // Divide by zero, unsigned and signed with a negative dividend.
    div_go(1'b0, 33'h0_1234_5678, 33'd0, 33'h1_FFFF_FFFF, 33'h0_1234_5678, 1'b1);
    release_starts(); wait_idle();
    div_go(1'b1, 33'h1_FFFF_FFF9, 33'd0, 33'h1_FFFF_FFFF, 33'h1_FFFF_FFF9, 1'b1);
    release_starts(); wait_idle();

    // Most-negative 32-bit value / -1, sign-extended to 33 bits.
    div_go(1'b1, 33'h1_8000_0000, 33'h1_FFFF_FFFF, 33'h0_8000_0000, 33'd0, 1'b0);
    release_starts(); wait_idle();

    // Unsigned large dividend.
    div_go(1'b0, 33'h1_FFFF_FFFF, 33'h0_0000_0010, 33'h0_1FFF_FFFF, 33'h0_0000_000F, 1'b0);
    release_starts(); wait_idle();

    // Multiplies; the first one runs concurrently with a divide.
    mul_go(1'b1, 33'h1_FFFF_FFFD, 33'd5, 66'h3_FFFF_FFFF_FFFF_FFF1);
    div_go(1'b1, 33'd100, 33'h1_FFFF_FFF9, 33'h1_FFFF_FFF2, 33'd2, 1'b0);
    release_starts(); wait_idle();
    mul_go(1'b0, 33'h0_FFFF_FFFF, 33'h0_FFFF_FFFF, 66'h0_FFFF_FFFE_0000_0001);
    release_starts(); wait_idle();
    mul_go(1'b1, 33'h1_FFFF_FFFD, 33'h1_FFFF_FFFB, 66'd15);
    release_starts(); wait_idle();
    mul_go(1'b1, 33'h0_FFFF_FFFF, 33'h1_FFFF_FFFF, 66'h3_FFFF_FFFF_0000_0001);
    release_starts(); wait_idle();

    // Reset halfway through CALC on both engines: nothing queued, no pulse may follow.
    bus.div_is_signed = 1'b0; bus.div_dividend = 33'd99; bus.div_divisor = 33'd3; bus.div_start = 1'b1;
    bus.mul_is_signed = 1'b0; bus.mul_multiplicand = 33'd9; bus.mul_multiplier = 33'd9; bus.mul_start = 1'b1;
    release_starts();
    repeat (SIZE / 2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_idle_reset("midreset");
    rst = 1'b0;
    repeat (SIZE + 6) @(negedge clk);

    // Fresh operations complete normally after the abort.
    div_go(1'b0, 33'd99, 33'd3, 33'd33, 33'd0, 1'b0);
    mul_go(1'b0, 33'd9, 33'd9, 66'd81);
    release_starts(); wait_idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/nbit_mul_div_unit.md
Name: nbit_mul_div_unit

Overview:
Iterative multi-cycle integer multiply/divide unit for the execute stage's RV32M path. It holds two independent engines, a divider and a multiplier, each with its own start/ready/valid handshake. Operands are SIZE bits wide (33 by default), so the caller can sign- or zero-extend 32-bit values and cover DIV/DIVU/REM/REMU and MUL/MULH/MULHU/MULHSU, including their overflow cases.

Parameters:
SIZE, 33, operand width in bits for both engines; the product is 2*SIZE bits.

Ports:
clk  in  1  clock; all state changes on its rising edge.
rst  in  1  reset; synchronous, active-high.
div_start  in  1  request a division; sampled only while div_ready=1.
div_is_signed  in  1  treat dividend and divisor as two's complement.
div_dividend  in  SIZE  dividend.
div_divisor  in  SIZE  divisor.
div_ready  out  1  divider idle and able to accept div_start.
div_valid  out  1  one-cycle pulse: quotient, remainder and error are valid.
div_error  out  1  divide-by-zero flag, meaningful while div_valid=1.
div_quotient  out  SIZE  quotient.
div_remainder  out  SIZE  remainder.
mul_start  in  1  request a multiplication; sampled only while mul_ready=1.
mul_is_signed  in  1  treat both operands as two's complement.
mul_multiplicand  in  SIZE  multiplicand.
mul_multiplier  in  SIZE  multiplier.
mul_ready  out  1  multiplier idle.
mul_valid  out  1  one-cycle pulse: product is valid.
mul_product  out  2*SIZE  product.

Behaviour:
- Reset (either engine, including mid-operation):
  - state returns to IDLE; any operation in flight is aborted and no valid pulse follows;
  - ready=1, valid=0, error=0;
  - quotient, remainder and product are 0.
- Each engine runs the FSM IDLE -> PREP -> CALC -> DONE -> IDLE.
  - IDLE: ready=1. On start=1 at an edge, latch operands and is_signed, go to PREP, drop ready on the next cycle.
  - start while not ready is ignored. Holding start high after acceptance does not launch a second operation.
  - PREP (1 cycle): if signed, take the absolute value of each operand and record the result signs.
  - CALC: exactly SIZE cycles, one bit per cycle.
    - Divider: restoring shift-subtract.
    - Multiplier: shift-add over the multiplier bits.
  - DONE (1 cycle): apply sign correction, register the results, and assert valid=1 and ready=1 in that same cycle.
  - Next cycle: valid=0, state IDLE.
- Latency: start accepted at edge E gives valid=1 in the cycle after edge E+SIZE+1. The latency is fixed and data-independent, including divide-by-zero.
- Result outputs hold their values from DONE until the next accepted start completes. Callers may sample them during the valid cycle or any later cycle.
- Divider arithmetic:
  - Unsigned mode: plain unsigned division.
  - Signed mode: the quotient is truncated toward zero, negated when operand signs differ; the remainder takes the sign of the dividend. Both are SIZE-bit two's complement.
  - Divisor=0: error=1, quotient all ones, remainder equals the original dividend (unmodified, in both modes).
  - Most-negative / -1 is computed without special-casing. With SIZE=33 and sign-extended 32-bit operands, -2^31/-1 gives quotient 0x0_8000_0000, whose low 32 bits are the RISC-V result; the remainder is 0.
- Multiplier arithmetic:
  - Signed mode: SIZE x SIZE two's complement giving a 2*SIZE two's complement product.
  - Unsigned mode: unsigned product.
  - Mixed signedness is handled by the caller zero-extending one operand while signed mode is selected.
- The two engines are fully independent and may run concurrently.

Decomposition:
- Shared package holds:
  - the FSM state encoding (IDLE, PREP, CALC, DONE);
  - a helper function for two's complement absolute value and negation at width SIZE.
- The top-level contains two sub-modules, div_nbit and mult_nbit. Each one is a single engine with the ports above minus the div_/mul_ prefix.

Test Plan:
- Unsigned divide, dividend 100, divisor 7 -> after SIZE+2 cycles a single valid pulse; quotient 14, remainder 2, error 0; ready returns high.
- Signed divide, -7 / 2 with SIZE=33 -> quotient 0x1_FFFF_FFFD (-3), remainder 0x1_FFFF_FFFF (-1).
- Divide by zero, dividend 0x0_1234_5678, divisor 0 -> error=1, quotient 0x1_FFFF_FFFF, remainder 0x0_1234_5678.
- Signed divide, 0x1_8000_0000 / 0x1_FFFF_FFFF -> quotient 0x0_8000_0000, remainder 0.
- Multiply:
  - signed -3 * 5 -> product equal to -15 at 66 bits;
  - unsigned 0x0_FFFF_FFFF squared -> low 64 bits 0xFFFF_FFFE_0000_0001.
- Handshake and reset:
  - a second start mid-operation is ignored and the first result is unchanged;
  - rst asserted halfway through CALC -> ready=1, valid=0, no later valid pulse; a fresh start then completes normally.
